dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8, SHALL set the max cycles a host request waits on CPU writes before the host is forced in (legal 1..15).
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_addr  input  4  CPU data-memory address (index register i).
REQ-005 cpu_wdata  input  4  CPU write data (data bus).
REQ-006 cpu_wren  input  1  CPU write enable (register_enables[7]).
REQ-007 host_req  input  1  host access request; level; held until host_gnt.
REQ-008 host_we  input  1  host write (1) / read (0); stable while host_req=1.
REQ-009 host_addr  input  4  host address; stable while host_req=1.
REQ-010 host_wdata  input  4  host write data; stable while host_req=1.
REQ-011 mem_q  input  4  data-memory read port (memory clocked on ~clk).
REQ-012 mem_addr  output  4  data-memory address.
REQ-013 mem_wdata  output  4  data-memory write data.
REQ-014 mem_wren  output  1  data-memory write enable.
REQ-015 cpu_stall  output  1  freezes CPU (pc, register enables) this cycle.
REQ-016 host_gnt  output  1  host access performed this cycle.
REQ-017 host_valid  output  1  one-cycle pulse: access complete, host_rdata valid for reads.
REQ-018 host_rdata  output  4  registered host read data.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, ACCESS, RESP; reset state IDLE.
REQ-020 IDLE: host_req=0 -> IDLE; host_req=1 and cpu_wren=0 -> ACCESS; host_req=1 and cpu_wren=1 -> WAIT with wait_cnt<=1.
REQ-021 WAIT: cpu_wren=0 -> ACCESS; cpu_wren=1 and wait_cnt=MAX_WAIT -> ACCESS (forced); else wait_cnt<=wait_cnt+1, stay WAIT.
REQ-022 wait_cnt SHALL be 4 bits, cleared on entry to ACCESS, never wrap.
REQ-023 ACCESS lasts exactly one cycle then -> RESP unconditionally.
REQ-024 RESP lasts exactly one cycle then -> IDLE unconditionally, regardless of host_req.
REQ-025 host_req still high in RESP SHALL be treated as a new request only from IDLE, guaranteeing at least one CPU-owned cycle between host accesses.
REQ-026 In ACCESS: mem_addr=host_addr, mem_wdata=host_wdata, mem_wren=host_we, cpu_stall=1, host_gnt=1 (all combinational from state).
REQ-027 In all other states: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_wren=cpu_wren, cpu_stall=0, host_gnt=0.
REQ-028 A cpu_wren asserted during ACCESS SHALL be dropped (stalled CPU reissues it).
REQ-029 On the posedge ending ACCESS with host_we=0, host_rdata<=mem_q; host_rdata SHALL hold until the next host read.
REQ-030 host_valid=1 only in RESP, for reads and writes.
REQ-031 Host latency: 2 cycles from request sample to host_valid with CPU idle; worst case MAX_WAIT+2.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, wait_cnt=0, host_rdata=0, cpu_stall=0, host_gnt=0, host_valid=0; mem_* then follow CPU inputs.
REQ-033 Reset mid-ACCESS SHALL deassert the host write immediately; no host_valid for the aborted access.
REQ-034 Reset release SHALL take effect on the first posedge clk with reset=1.

Verification
REQ-035 Host write addr 0x5 data 0xA, cpu_wren=0 -> host_gnt cycle 1 with mem_wren=1, mem_addr=5, mem_wdata=A; host_valid cycle 2; cpu_stall only in cycle 1.
REQ-036 Memory word 0x3=0x6, host read addr 3 -> host_valid with host_rdata=0x6; host_rdata still 0x6 after subsequent host write.
REQ-037 cpu_wren held 1, MAX_WAIT=8, host_req raised -> 8 WAIT cycles with CPU writes passing, forced ACCESS on 9th cycle, cpu_stall=1 that cycle only.
REQ-038 cpu_wren drops after 3 WAIT cycles -> ACCESS next cycle, wait_cnt=0 afterward.
REQ-039 host_req held high for back-to-back reads -> pattern ACCESS,RESP,IDLE repeating; cpu_stall never high two consecutive cycles.
REQ-040 reset pulled low during ACCESS of write -> mem_wren follows cpu_wren same cycle, no host_valid, FSM in IDLE after release.

Source files
------------

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data-memory port arbiter between the CPU and a host access port
//
// Purpose: shares one data-memory port between the CPU (default owner) and a
// host. A host request is granted one ACCESS cycle, during which the CPU is
// stalled, followed by a RESP cycle that reports completion. Host requests
// defer to CPU writes for at most MAX_WAIT cycles before being forced in.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cpu_addr/cpu_wdata/cpu_wren CPU side of the memory port
//   host_req/host_we/           host request (level, held until host_gnt)
//   host_addr/host_wdata
//   mem_q                       memory read data (memory clocked on ~clk)
//   mem_addr/mem_wdata/mem_wren muxed memory port
//   cpu_stall                   freezes the CPU during the host access cycle
//   host_gnt                    host access performed this cycle
//   host_valid                  one-cycle completion pulse
//   host_rdata                  registered host read data

module dm_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  input  logic       cpu_wren,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [3:0] host_wdata,
  input  logic [3:0] mem_q,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_wdata,
  output logic       mem_wren,
  output logic       cpu_stall,
  output logic       host_gnt,
  output logic       host_valid,
  output logic [3:0] host_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (host_req) begin
          if (cpu_wren) begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 4'd1;
          end else begin
            state_nxt    = ACCESS;
            wait_cnt_nxt = 4'd0;
          end
        end
      end
      WAIT: begin
        // The counter stops at WAIT_LIMIT (<= 15), so it can never wrap.
        if (!cpu_wren || (wait_cnt == WAIT_LIMIT)) begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      ACCESS: state_nxt = RESP;
      // Always return to IDLE so the CPU owns at least one cycle between
      // host accesses even if host_req stays high.
      RESP:   state_nxt = IDLE;
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      host_rdata <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      // mem_q was sampled on the falling edge inside ACCESS.
      if ((state == ACCESS) && !host_we) begin
        host_rdata <= mem_q;
      end
    end
  end

  // Port mux is purely a function of state, so an asynchronous reset drops
  // any in-flight host write in the same cycle.
  assign host_gnt   = (state == ACCESS);
  assign cpu_stall  = host_gnt;
  assign host_valid = (state == RESP);
  assign mem_addr   = host_gnt ? host_addr  : cpu_addr;
  assign mem_wdata  = host_gnt ? host_wdata : cpu_wdata;
  assign mem_wren   = host_gnt ? host_we    : cpu_wren;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter against a transaction-level model

module tb_dm_arbiter;

  localparam int MAX_WAIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cpu_addr, cpu_wdata;
  logic       cpu_wren;
  logic       host_req, host_we;
  logic [3:0] host_addr, host_wdata;
  logic [3:0] mem_q;
  logic [3:0] mem_addr, mem_wdata;
  logic       mem_wren, cpu_stall, host_gnt, host_valid;
  logic [3:0] host_rdata;

  dm_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .mem_q(mem_q),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .cpu_stall(cpu_stall), .host_gnt(host_gnt), .host_valid(host_valid),
    .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  // Data memory clocked on the falling edge, read-before-write.
  logic [3:0] mem [16];
  always @(negedge clk) begin
    mem_q <= mem[mem_addr];
    if (mem_wren) mem[mem_addr] <= mem_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks a host transaction as "pending / granted / answered".
  logic [3:0] ref_mem [16];
  bit         m_gnt, m_valid, m_pending;
  int         m_waited;
  logic [3:0] m_rdata;
  bit         n_gnt, n_valid, n_pending;
  int         n_waited;
  logic [3:0] n_rdata;
  logic       obs_gnt, obs_stall, obs_valid, obs_wren;
  logic [3:0] obs_rdata, obs_addr;

  task automatic model_clear();
    m_gnt = 0; m_valid = 0; m_pending = 0; m_waited = 0; m_rdata = 4'd0;
    n_gnt = 0; n_valid = 0; n_pending = 0; n_waited = 0; n_rdata = 4'd0;
  endtask

  task automatic check_outputs(input bit step_model);
    logic       e_wren;
    logic [3:0] e_addr, e_wdata;
    e_addr  = m_gnt ? host_addr  : cpu_addr;
    e_wdata = m_gnt ? host_wdata : cpu_wdata;
    e_wren  = m_gnt ? host_we    : cpu_wren;
    chk("host_gnt",   host_gnt,   m_gnt);
    chk("cpu_stall",  cpu_stall,  m_gnt);
    chk("host_valid", host_valid, m_valid);
    chk("mem_addr",   mem_addr,   e_addr);
    chk("mem_wdata",  mem_wdata,  e_wdata);
    chk("mem_wren",   mem_wren,   e_wren);
    chk("host_rdata", host_rdata, m_rdata);
    chk("wait_cnt",   {28'd0, dut.wait_cnt}, m_waited);
    obs_gnt = host_gnt; obs_stall = cpu_stall; obs_valid = host_valid;
    obs_wren = mem_wren; obs_rdata = host_rdata; obs_addr = mem_addr;
    if (!step_model) return;
    if (e_wren) ref_mem[e_addr] = e_wdata;
    n_valid = 0; n_gnt = 0; n_pending = m_pending; n_waited = m_waited; n_rdata = m_rdata;
    if (reset) begin
      n_valid = m_gnt;
      if (m_gnt) begin
        if (!host_we) n_rdata = ref_mem[host_addr];
      end else if (m_valid) begin
        // response cycle: host_req is ignored here
      end else if (m_pending) begin
        if (!cpu_wren || m_waited >= MAX_WAIT) begin
          n_gnt = 1; n_pending = 0; n_waited = 0;
        end else begin
          n_waited = m_waited + 1;
        end
      end else if (host_req) begin
        if (!cpu_wren) n_gnt = 1;
        else begin n_pending = 1; n_waited = 1; end
      end
    end else begin
      n_pending = 0; n_waited = 0; n_rdata = 4'd0;
    end
  endtask

  // One clock: check at falling edge, advance model after rising edge.
  task automatic cycle();
    @(negedge clk); #1;
    check_outputs(1'b1);
    @(posedge clk); #1;
    m_gnt = n_gnt; m_valid = n_valid; m_pending = n_pending;
    m_waited = n_waited; m_rdata = n_rdata;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check_outputs(1'b0);
  endtask

  task automatic host_set(input logic req, input logic we, input logic [3:0] a, input logic [3:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  int gnt_idx, stall_cnt;
  bit prev_stall;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 4'($urandom);
      ref_mem[i] = mem[i];
    end
    cpu_addr = 0; cpu_wdata = 0; cpu_wren = 0;
    host_set(0, 0, 0, 0);
    assert_reset();
    cycle(); cycle();
    reset = 1'b1;
    cycle();

    // Host write 0x5 <- 0xA with CPU idle.
    host_set(1, 1, 4'h5, 4'hA);
    cycle();
    chk("w_idle_nogrant", obs_gnt, 0);
    cycle();
    chk("w_gnt", obs_gnt, 1);
    chk("w_wren", obs_wren, 1);
    chk("w_addr", obs_addr, 4'h5);
    chk("w_stall", obs_stall, 1);
    host_req = 0;
    cycle();
    chk("w_valid", obs_valid, 1);
    chk("w_stall_resp", obs_stall, 0);
    cycle();

    // Write 0x3 <- 0x6, read it back, then an unrelated write.
    host_set(1, 1, 4'h3, 4'h6);
    cycle(); cycle(); host_req = 0; cycle(); cycle();
    host_set(1, 0, 4'h3, 4'h0);
    cycle(); cycle(); host_req = 0; cycle();
    chk("r_valid", obs_valid, 1);
    chk("r_rdata", obs_rdata, 4'h6);
    cycle();
    host_set(1, 1, 4'h9, 4'hF);
    cycle(); cycle(); host_req = 0; cycle(); cycle();
    chk("r_rdata_hold", obs_rdata, 4'h6);

    // CPU writes continuously: host forced in after MAX_WAIT wait cycles.
    cpu_wren = 1; cpu_addr = 4'hC; cpu_wdata = 4'h1;
    host_set(1, 0, 4'h5, 4'h0);
    gnt_idx = -1; stall_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (obs_stall) stall_cnt++;
      if (obs_gnt && gnt_idx < 0) begin gnt_idx = c; host_req = 0; end
    end
    chk("force_gnt_cycle", gnt_idx, MAX_WAIT + 1);
    chk("force_stall_cnt", stall_cnt, 1);

    // CPU write drops in the third wait cycle: grant follows immediately.
    host_set(1, 0, 4'h3, 4'h0);
    gnt_idx = -1;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) cpu_wren = 0;
      cycle();
      if (obs_gnt && gnt_idx < 0) begin gnt_idx = c; host_req = 0; end
    end
    chk("drop_gnt_cycle", gnt_idx, 4);
    chk("drop_wait_cnt", {28'd0, dut.wait_cnt}, 0);

    // host_req held high: ACCESS/RESP/IDLE pattern, never back-to-back stalls.
    host_set(1, 0, 4'h3, 4'h0);
    stall_cnt = 0; prev_stall = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (obs_stall) stall_cnt++;
      chk("b2b_no_double_stall", obs_stall && prev_stall, 0);
      prev_stall = obs_stall;
    end
    chk("b2b_gnt_count", stall_cnt, 4);
    host_req = 0;
    cycle(); cycle();

    // Reset during a host write ACCESS.
    host_set(1, 1, 4'h7, 4'h4);
    cycle();
    cpu_wren = 1; cpu_addr = 4'h2; cpu_wdata = 4'h7;
    assert_reset();
    chk("rst_wren_cpu", obs_wren, 1);
    chk("rst_addr_cpu", obs_addr, 4'h2);
    chk("rst_no_gnt", obs_gnt, 0);
    cycle();
    reset = 1'b1; host_req = 0; cpu_wren = 0;
    cycle();
    chk("rst_no_valid0", obs_valid, 0);
    cycle();
    chk("rst_no_valid1", obs_valid, 0);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      cpu_wren  = ($urandom_range(0, 3) != 0);
      cpu_addr  = 4'($urandom);
      cpu_wdata = 4'($urandom);
      if (!host_req) begin
        if ($urandom_range(0, 2) == 0)
          host_set(1, 1'($urandom), 4'($urandom), 4'($urandom));
      end else if (obs_gnt && $urandom_range(0, 1) == 0) begin
        host_req = 0;
      end
      if ($urandom_range(0, 199) == 0) begin
        assert_reset();
        cycle();
        reset = 1'b1;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
